// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem requests, one-entry skid,
// branch redirect with flush, and halt-opcode detection.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [7:0]        instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic {RUN, HALT} state_e;

    state_e            state_q;
    logic              en_q;
    logic              pend_q;
    logic              skv_q;
    logic              valid_q;
    logic              halted_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] tag_q;
    logic [ADDR_W-1:0] skp_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [7:0]        skd_q;
    logic [7:0]        instr_q;

    logic              req;
    logic              move;
    logic              halt_hit;
    logic [7:0]        mv_data;
    logic [ADDR_W-1:0] mv_pc;

    assign req       = en_q & ~stall;
    assign imem_en   = req;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign valid     = valid_q;
    assign pc_out    = pc_out_q;
    assign halted    = halted_q;

    // The skid entry is older than the response in flight, so it goes first.
    always_comb begin
        move     = ~stall & (skv_q | pend_q);
        mv_data  = skv_q ? skd_q : imem_rdata;
        mv_pc    = skv_q ? skp_q : tag_q;
        halt_hit = move & (mv_data[7:4] == HALT_OP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
            skv_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
            tag_q    <= '0;
            skp_q    <= '0;
            pc_out_q <= '0;
            skd_q    <= '0;
            instr_q  <= '0;
        end else if (redirect) begin
            state_q  <= RUN;
            en_q     <= 1'b1;
            pend_q   <= 1'b0;
            skv_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            pc_q     <= redirect_pc;
        end else begin
            en_q   <= (state_q == RUN);
            pend_q <= req;
            tag_q  <= pc_q;
            if (req) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
            if (stall) begin
                if (pend_q) begin
                    skv_q <= 1'b1;
                    skd_q <= imem_rdata;
                    skp_q <= tag_q;
                end
            end else if (move) begin
                instr_q  <= mv_data;
                pc_out_q <= mv_pc;
                valid_q  <= 1'b1;
                skv_q    <= skv_q & pend_q;
                skd_q    <= imem_rdata;
                skp_q    <= tag_q;
            end else begin
                valid_q <= 1'b0;
            end
            // Halt drops everything younger than the halt instruction.
            if (halt_hit) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
                en_q     <= 1'b0;
                pend_q   <= 1'b0;
                skv_q    <= 1'b0;
            end
        end
    end

endmodule
